vdp_vram_slot_arbiter: RTL

//  Per-dot VRAM slot arbiter for the VDP. Shares one VRAM port between four requesters:
//  - display fetch and sprite engine (hard real-time; sprite takes SPVRAMACCESSING/PRAMADR);
//  - CPU and command engine (req/ack handshake).

---
 rtl/vdp_arb_pkg.sv | 17 +
 rtl/vdp_arb_port.sv | 59 +++++
 rtl/vdp_vram_slot_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/vdp_arb_pkg.sv
// Shared types and constants for the VDP VRAM slot arbiter.
package vdp_arb_pkg;

  localparam int VRAM_AW = 17;

  localparam logic [1:0] DS_BOUNDARY = 2'b10;
  localparam logic [1:0] DS_CAPTURE  = 2'b11;

  typedef enum logic [2:0] {
    GNT_IDLE,
    GNT_DISP,
    GNT_SPRITE,
    GNT_CPU,
    GNT_CMD
  } gnt_e;

endpackage

// File: rtl/vdp_arb_port.sv
// One req/ack requester port: pending/re-arm, ACK pulse and read-data capture.
module vdp_arb_port
  import vdp_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] dotstate_i,
  input  logic       req_i,
  input  logic       we_i,
  input  logic       grant_i,
  input  logic [7:0] pramdat_i,
  output logic       pending_o,
  output logic       ack_o,
  output logic [7:0] rdata_o
);

  logic       busy_q, busy_d;
  logic       wr_q, wr_d;
  logic       ack_q, ack_d;
  logic [7:0] rdata_q, rdata_d;
  logic       capture;

  assign capture = (dotstate_i == DS_CAPTURE);

  // The ACK cycle doubles as the re-arm cycle: a still-high REQ is stale there.
  assign pending_o = req_i & ~ack_q;
  assign ack_o     = ack_q;
  assign rdata_o   = rdata_q;

  always_comb begin
    busy_d  = busy_q;
    wr_d    = wr_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    if (grant_i) begin
      busy_d = 1'b1;
      wr_d   = we_i;
    end else if (capture && busy_q) begin
      busy_d = 1'b0;
      ack_d  = 1'b1;
      if (!wr_q) rdata_d = pramdat_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      busy_q  <= busy_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: rtl/vdp_vram_slot_arbiter.sv
// Per-dot VRAM slot arbiter: display > sprite > round-robin(CPU, CMD), one access per dot.
module vdp_vram_slot_arbiter
  import vdp_arb_pkg::*;
#(
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic               CLK21M,
  input  logic               RESET,
  input  logic [1:0]         DOTSTATE,
  input  logic               DISP_REQ,
  input  logic [VRAM_AW-1:0] DISP_ADR,
  input  logic               SP_ACC,
  input  logic [VRAM_AW-1:0] SP_ADR,
  input  logic               CPU_REQ,
  input  logic               CPU_WE,
  input  logic [VRAM_AW-1:0] CPU_ADR,
  input  logic [7:0]         CPU_WDATA,
  output logic               CPU_ACK,
  output logic [7:0]         CPU_RDATA,
  input  logic               CMD_REQ,
  input  logic               CMD_WE,
  input  logic [VRAM_AW-1:0] CMD_ADR,
  input  logic [7:0]         CMD_WDATA,
  output logic               CMD_ACK,
  output logic [7:0]         CMD_RDATA,
  output logic [VRAM_AW-1:0] VRAM_ADR,
  output logic               VRAM_WE,
  output logic [7:0]         VRAM_WDATA,
  input  logic [7:0]         PRAMDAT,
  output logic [2:0]         GRANT,
  output logic               WAIT_OVF,
  input  logic               WAIT_CLR
);

  localparam logic [7:0] MAX_WAIT = 8'(CPU_MAX_WAIT);

  gnt_e               grant_q, win;
  logic [VRAM_AW-1:0] adr_q, win_adr;
  logic               we_q, win_we;
  logic [7:0]         wdata_q, win_wdata;
  logic               last_cmd_q;
  logic [7:0]         cnt_q, cnt_d;
  logic               ovf_q, ovf_set;
  logic               boundary, cpu_pend, cmd_pend;

  assign boundary = (DOTSTATE == DS_BOUNDARY);

  vdp_arb_port u_cpu_port (
    .clk_i(CLK21M), .rst_i(RESET), .dotstate_i(DOTSTATE),
    .req_i(CPU_REQ), .we_i(CPU_WE), .grant_i(boundary && (win == GNT_CPU)),
    .pramdat_i(PRAMDAT), .pending_o(cpu_pend), .ack_o(CPU_ACK), .rdata_o(CPU_RDATA)
  );

  vdp_arb_port u_cmd_port (
    .clk_i(CLK21M), .rst_i(RESET), .dotstate_i(DOTSTATE),
    .req_i(CMD_REQ), .we_i(CMD_WE), .grant_i(boundary && (win == GNT_CMD)),
    .pramdat_i(PRAMDAT), .pending_o(cmd_pend), .ack_o(CMD_ACK), .rdata_o(CMD_RDATA)
  );

  always_comb begin
    win = GNT_IDLE;
    if (DISP_REQ)                  win = GNT_DISP;
    else if (SP_ACC)               win = GNT_SPRITE;
    else if (cpu_pend && cmd_pend) win = last_cmd_q ? GNT_CPU : GNT_CMD;
    else if (cpu_pend)             win = GNT_CPU;
    else if (cmd_pend)             win = GNT_CMD;
  end

  // Idle slots hold the previous address; only handshake ports carry write data.
  always_comb begin
    win_adr   = adr_q;
    win_we    = 1'b0;
    win_wdata = wdata_q;
    case (win)
      GNT_DISP:   win_adr = DISP_ADR;
      GNT_SPRITE: win_adr = SP_ADR;
      GNT_CPU: begin
        win_adr   = CPU_ADR;
        win_we    = CPU_WE;
        win_wdata = CPU_WDATA;
      end
      GNT_CMD: begin
        win_adr   = CMD_ADR;
        win_we    = CMD_WE;
        win_wdata = CMD_WDATA;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    if (!CPU_REQ) begin
      cnt_d = 8'h00;
    end else if (boundary) begin
      if (win == GNT_CPU) begin
        cnt_d = 8'h00;
      end else if (cpu_pend) begin
        if (cnt_q != MAX_WAIT) cnt_d = cnt_q + 8'd1;
        ovf_set = (cnt_d == MAX_WAIT);
      end
    end
  end

  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      grant_q    <= GNT_IDLE;
      adr_q      <= '0;
      we_q       <= 1'b0;
      wdata_q    <= 8'h00;
      last_cmd_q <= 1'b1;
      cnt_q      <= 8'h00;
      ovf_q      <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_set | (ovf_q & ~WAIT_CLR);
      if (boundary) begin
        grant_q <= win;
        adr_q   <= win_adr;
        we_q    <= win_we;
        wdata_q <= win_wdata;
        if (win == GNT_CPU)      last_cmd_q <= 1'b0;
        else if (win == GNT_CMD) last_cmd_q <= 1'b1;
      end else if (DOTSTATE == DS_CAPTURE) begin
        // Write strobe drops one cycle early so the slot ends with WE low.
        we_q <= 1'b0;
      end
    end
  end

  assign GRANT      = grant_q;
  assign VRAM_ADR   = adr_q;
  assign VRAM_WE    = we_q;
  assign VRAM_WDATA = wdata_q;
  assign WAIT_OVF   = ovf_q;

endmodule
